// File: rtl/gfe_tx_serdes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gfe_tx_serdes_pkg : shared codes, FSM encodings and word type for    |
// |                     the XGMII-like to GMII/MII transmit serializer   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package gfe_tx_serdes_pkg;

  localparam logic [7:0] c_START     = 8'hFB;
  localparam logic [7:0] c_TERMINATE = 8'hFD;
  localparam logic [7:0] c_ERROR     = 8'hFE;
  localparam logic [7:0] c_IDLE      = 8'h07;
  localparam logic [7:0] c_PREAMBLE  = 8'h55;
  localparam logic [7:0] c_SFD       = 8'hD5;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_FRAME = 2'd1;
  localparam logic [1:0] c_ST_ABORT = 2'd2;

  typedef struct packed {
    logic [7:0]  c;
    logic [63:0] d;
  } xword_t;

  function automatic logic [7:0] lane_byte(input logic [63:0] w, input logic [2:0] k);
    return w[{k, 3'b000} +: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/gfe_tx_serdes_word_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gfe_word_fifo : synchronous 72-bit word FIFO, power-of-two depth     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gfe_word_fifo #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [71:0]                   data_i,
  output logic [71:0]                   data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [71:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          w_push;
  logic          w_pop;

  assign full_o  = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (w_push) wr_q <= wr_q + 1'b1;
      if (w_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  // Storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/gfe_tx_serdes.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gfe_tx_serdes : 64-bit XGMII-like words to octet en/er/d stream.     |
// | Optional macro GFE_TX_ERR_CNT_EN enables the saturating err counter. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gfe_tx_serdes
  import gfe_tx_serdes_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        octet_en_i,
  input  logic [63:0] xd_i,
  input  logic [7:0]  xc_i,
  input  logic        xvalid_i,
  output logic        xready_o,
  output logic        en_o,
  output logic        er_o,
  output logic [7:0]  d_o,
  output logic [15:0] err_cnt_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  xword_t          w_head;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_push;
  logic            w_pop;
  logic            w_lane0;
  logic            w_have;
  logic            w_ctl;
  logic [7:0]      w_byte;
  logic            w_err_evt;

  logic            xready_q;
  logic [2:0]      lane_q,     lane_d;
  logic [1:0]      state_q,    state_d;
  xword_t          word_q,     word_d;
  logic            word_vld_q, word_vld_d;
  logic            en_q,       en_d;
  logic            er_q,       er_d;
  logic [7:0]      d_q,        d_d;

  assign w_lane0   = (lane_q == 3'd0);
  assign w_push    = xvalid_i & xready_q & ~w_full;
  assign w_pop     = octet_en_i & w_lane0 & ~w_empty;
  assign w_cnt_nxt = w_count + CW'(w_push) - CW'(w_pop);

  gfe_word_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  ({xc_i, xd_i}),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  // Lane 0 is taken straight from the FIFO head in the slot that pops it.
  always_comb begin
    if (w_lane0) begin
      w_have = ~w_empty;
      w_byte = lane_byte(w_head.d, 3'd0);
      w_ctl  = w_head.c[0];
    end else begin
      w_have = word_vld_q;
      w_byte = lane_byte(word_q.d, lane_q);
      w_ctl  = word_q.c[lane_q];
    end
  end

  always_comb begin
    lane_d     = lane_q;
    state_d    = state_q;
    word_d     = word_q;
    word_vld_d = word_vld_q;
    en_d       = en_q;
    er_d       = er_q;
    d_d        = d_q;
    w_err_evt  = 1'b0;
    if (octet_en_i) begin
      lane_d = lane_q + 3'd1;
      en_d   = 1'b0;
      er_d   = 1'b0;
      d_d    = 8'h00;
      if (w_lane0) begin
        word_vld_d = ~w_empty;
        word_d     = w_head;
      end
      case (state_q)
        c_ST_IDLE: begin
          if (w_have && w_ctl && (w_byte == c_START)) begin
            if (w_lane0) begin
              en_d    = 1'b1;
              d_d     = c_PREAMBLE;
              state_d = c_ST_FRAME;
            end else begin
              w_err_evt = 1'b1;
            end
          end
        end
        c_ST_FRAME: begin
          if (!w_have) begin
            if (w_lane0) begin
              en_d      = 1'b1;
              er_d      = 1'b1;
              w_err_evt = 1'b1;
              state_d   = c_ST_ABORT;
            end
          end else if (!w_ctl) begin
            en_d = 1'b1;
            d_d  = w_byte;
          end else if (w_byte == c_ERROR) begin
            en_d = 1'b1;
            er_d = 1'b1;
            d_d  = c_ERROR;
          end else if (w_byte == c_TERMINATE) begin
            state_d    = c_ST_IDLE;
            word_vld_d = 1'b0;
          end else begin
            en_d      = 1'b1;
            er_d      = 1'b1;
            d_d       = w_byte;
            w_err_evt = 1'b1;
          end
        end
        c_ST_ABORT: begin
          if (w_have && w_ctl && (w_byte == c_TERMINATE)) begin
            state_d    = c_ST_IDLE;
            word_vld_d = 1'b0;
          end
        end
        default: state_d = c_ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xready_q   <= 1'b0;
      lane_q     <= 3'd0;
      state_q    <= c_ST_IDLE;
      word_q     <= '0;
      word_vld_q <= 1'b0;
      en_q       <= 1'b0;
      er_q       <= 1'b0;
      d_q        <= 8'h00;
    end else begin
      xready_q   <= (w_cnt_nxt < CW'(FIFO_DEPTH));
      lane_q     <= lane_d;
      state_q    <= state_d;
      word_q     <= word_d;
      word_vld_q <= word_vld_d;
      en_q       <= en_d;
      er_q       <= er_d;
      d_q        <= d_d;
    end
  end

  assign xready_o = xready_q;
  assign en_o     = en_q;
  assign er_o     = er_q;
  assign d_o      = d_q;

`ifdef GFE_TX_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 16'h0000;
    end else if (w_err_evt && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  logic w_unused_err_evt;
  assign w_unused_err_evt = w_err_evt;
  assign err_cnt_o        = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gfe_tx_serdes.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gfe_tx_serdes : self-checking bench for gfe_tx_serdes             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_gfe_tx_serdes;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        octet_en_i = 1'b0;
  logic [63:0] xd_i = '0;
  logic [7:0]  xc_i = '0;
  logic        xvalid_i = 1'b0;
  logic        xready_o;
  logic        en_o;
  logic        er_o;
  logic [7:0]  d_o;
  logic [15:0] err_cnt_o;

  int          checks = 0;
  int          errors = 0;
  int          en_mode = 0;
  logic        ph = 1'b0;
  logic        slot_seen = 1'b0;
  int          nslot = 0;
  int          exp_err = 0;
  logic [9:0]  prev = '0;
  logic        prev_ok = 1'b0;
  logic [71:0] sent_q[$];
  logic [8:0]  got[$];
  logic [8:0]  exp_q[$];

  gfe_tx_serdes #(.FIFO_DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .octet_en_i (octet_en_i),
    .xd_i       (xd_i),
    .xc_i       (xc_i),
    .xvalid_i   (xvalid_i),
    .xready_o   (xready_o),
    .en_o       (en_o),
    .er_o       (er_o),
    .d_o        (d_o),
    .err_cnt_o  (err_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Slot pacing: GE every cycle, FE 1-in-2, or a random pattern.
  always @(posedge clk) begin
    #1;
    ph <= ~ph;
    case (en_mode)
      0:       octet_en_i <= 1'b1;
      1:       octet_en_i <= ph;
      default: octet_en_i <= ($urandom_range(0, 2) != 0);
    endcase
  end

  always @(posedge clk) slot_seen <= octet_en_i;

  always @(posedge clk or posedge rst) begin
    if (rst) nslot <= 0;
    else if (octet_en_i) nslot <= nslot + 1;
  end

  // Collect enabled octets once per slot; outputs must be held between slots.
  always @(negedge clk) begin
    if (rst) begin
      prev_ok <= 1'b0;
    end else begin
      if (slot_seen) begin
        if (en_o) got.push_back({er_o, d_o});
        else chk("idle_er", 32'(er_o), 32'd0);
      end else if (prev_ok) begin
        chk("hold", 32'({en_o, er_o, d_o}), 32'(prev));
      end
      prev    <= {en_o, er_o, d_o};
      prev_ok <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [63:0] d, input logic [7:0] c);
    int n = 0;
    xd_i = d;
    xc_i = c;
    xvalid_i = 1'b1;
    while (xready_o !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk("send_timeout", 32'(n < 400), 32'd1);
    if (n < 400) begin
      tick();
      sent_q.push_back({c, d});
    end
    xvalid_i = 1'b0;
  endtask

  task automatic seg_begin();
    sent_q.delete();
    got.delete();
  endtask

  function automatic logic [8:0] got_at(input int i);
    return (i < got.size()) ? got[i] : 9'bx;
  endfunction

  // Reference: walk the accepted words byte by byte and list the en=1 octets.
  task automatic run_model(output int nerr);
    int st;
    logic [7:0] b;
    logic c;
    nerr = 0;
    st = 0;
    exp_q.delete();
    foreach (sent_q[i]) begin
      for (int k = 0; k < 8; k++) begin
        b = sent_q[i][8*k +: 8];
        c = sent_q[i][64+k];
        if (st == 0) begin
          if (c && b == 8'hFB) begin
            if (k == 0) begin
              exp_q.push_back({1'b0, 8'h55});
              st = 1;
            end else begin
              nerr++;
            end
          end
        end else begin
          if (!c) exp_q.push_back({1'b0, b});
          else if (b == 8'hFE) exp_q.push_back({1'b1, 8'hFE});
          else if (b == 8'hFD) begin
            st = 0;
            break;
          end else begin
            exp_q.push_back({1'b1, b});
            nerr++;
          end
        end
      end
    end
  endtask

  task automatic chk_errcnt(input string tag);
`ifdef GFE_TX_ERR_CNT_EN
    chk(tag, 32'(err_cnt_o), 32'(exp_err));
`else
    chk(tag, 32'(err_cnt_o), 32'd0);
`endif
  endtask

  task automatic seg_check(input string tag);
    int ne;
    run_model(ne);
    exp_err += ne;
    chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_oct%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    chk_errcnt({tag, "_errcnt"});
  endtask

  task automatic send_frame(input int ndata);
    logic [63:0] d;
    logic [7:0]  c;
    int p;
    send_word(64'hD5555555555555FB, 8'h01);
    for (int w = 0; w < ndata; w++) begin
      d = {$urandom, $urandom};
      c = '0;
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 9) == 0) begin
          c[k] = 1'b1;
          case ($urandom_range(0, 2))
            0:       d[8*k +: 8] = 8'hFE;
            1:       d[8*k +: 8] = 8'h07;
            default: d[8*k +: 8] = 8'hFB;
          endcase
        end
      end
      send_word(d, c);
    end
    p = $urandom_range(0, 7);
    d = {$urandom, $urandom};
    c = '0;
    for (int k = 0; k < 8; k++) begin
      if (k == p) begin
        d[8*k +: 8] = 8'hFD;
        c[k] = 1'b1;
      end else if (k > p) begin
        d[8*k +: 8] = 8'h07;
        c[k] = 1'b1;
      end
    end
    send_word(d, c);
  endtask

  task automatic send_idle(input bit bad_start);
    logic [63:0] d;
    int q;
    d = 64'h0707070707070707;
    if (bad_start) begin
      q = $urandom_range(1, 7);
      d[8*q +: 8] = 8'hFB;
    end
    send_word(d, 8'hFF);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    en_mode = 0;
    repeat (3) tick();
    chk("rst_en", 32'(en_o), 32'd0);
    chk("rst_er", 32'(er_o), 32'd0);
    chk("rst_d", 32'(d_o), 32'd0);
    chk("rst_xready", 32'(xready_o), 32'd0);
    chk("rst_errcnt", 32'(err_cnt_o), 32'd0);
    rst = 1'b0;
    exp_err = 0;
    tick();
    chk("xready_after_rst", 32'(xready_o), 32'd1);

    // GE reference frame
    seg_begin();
    send_word(64'hD5555555555555FB, 8'h01);
    send_word(64'h0807060504030201, 8'h00);
    send_word(64'h07070707070707FD, 8'hFF);
    repeat (60) tick();
    chk("ge_count16", 32'(got.size()), 32'd16);
    chk("ge_first", 32'(got_at(0)), 32'h055);
    chk("ge_sfd", 32'(got_at(7)), 32'h0D5);
    chk("ge_d01", 32'(got_at(8)), 32'h001);
    chk("ge_d08", 32'(got_at(15)), 32'h008);
    seg_check("ge");

    // In-frame ERROR control in lane 3
    seg_begin();
    send_word(64'hD5555555555555FB, 8'h01);
    send_word(64'h08070605FE030201, 8'h08);
    send_word(64'h07070707070707FD, 8'hFF);
    repeat (60) tick();
    chk("l3_prev", 32'(got_at(10)), 32'h003);
    chk("l3_err", 32'(got_at(11)), 32'h1FE);
    chk("l3_next", 32'(got_at(12)), 32'h005);
    seg_check("lane3");

    // FE pacing, same frame
    en_mode = 1;
    seg_begin();
    send_word(64'hD5555555555555FB, 8'h01);
    send_word(64'h0807060504030201, 8'h00);
    send_word(64'h07070707070707FD, 8'hFF);
    repeat (120) tick();
    chk("fe_count16", 32'(got.size()), 32'd16);
    seg_check("fe");

    // Underrun after the start word
    en_mode = 0;
    seg_begin();
    send_word(64'hD5555555555555FB, 8'h01);
    repeat (30) tick();
    send_word(64'h0807060504030201, 8'h00);
    send_word(64'h07070707070707FD, 8'hFF);
    send_idle(1'b0);
    repeat (60) tick();
    exp_err += 1;
    chk("ur_len", 32'(got.size()), 32'd9);
    for (int i = 0; i < 7; i++) chk($sformatf("ur_pre%0d", i), 32'(got_at(i)), 32'h055);
    chk("ur_sfd", 32'(got_at(7)), 32'h0D5);
    chk("ur_slot", 32'(got_at(8)), 32'h100);
    chk_errcnt("ur_errcnt");

    // Random frames under continuous xvalid and random slot pacing
    en_mode = 2;
    seg_begin();
    for (int f = 0; f < 6; f++) begin
      send_frame($urandom_range(0, 3));
      send_idle($urandom_range(0, 1) == 1);
    end
    repeat (300) tick();
    seg_check("rnd");

    // Reset in the middle of a frame at lane 4
    en_mode = 0;
    repeat (20) tick();
    seg_begin();
    send_word(64'hD5555555555555FB, 8'h01);
    send_word(64'h0807060504030201, 8'h00);
    send_word(64'h07070707070707FD, 8'hFF);
    n = 0;
    while (!((nslot % 8) == 5 && got.size() >= 4) && n < 200) begin
      tick();
      n++;
    end
    chk("mid_wait", 32'(n < 200), 32'd1);
    chk("mid_en_before", 32'(en_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_en", 32'(en_o), 32'd0);
    chk("mid_rst_er", 32'(er_o), 32'd0);
    chk("mid_rst_d", 32'(d_o), 32'd0);
    chk("mid_rst_xready", 32'(xready_o), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    exp_err = 0;
    tick();
    seg_begin();
    send_frame(2);
    send_idle(1'b0);
    repeat (60) tick();
    seg_check("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
